// File: rtl/lvds_soft_deser_align_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : lvds_pkg                                                    |
// | Purpose    : Shared types and constants for the soft LVDS deserialiser   |
// |              and word aligner: alignment state enum, word width and the  |
// |              default training/sync word.                                 |
// | Ports      : none                                                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package lvds_pkg;

  localparam int unsigned c_word_w = 8;

  localparam logic [c_word_w-1:0] c_sync_word = 8'hA5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lvds_state_e;

endpackage
`default_nettype wire

// File: rtl/lvds_soft_deser_align_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : lvds_soft_deser_align_if                                    |
// | Purpose    : Bundles the serial input, realign request and the aligned   |
// |              parallel receive outputs of the LVDS deserialiser.          |
// | Signals    : rx_in, realign            (towards the receiver)            |
// |              rx_data[7:0], rx_valid,   (from the receiver)               |
// |              rx_sync, locked, lock_lost                                  |
// | Modports   : master - drives the serial side, observes the outputs       |
// |              slave  - the receiver itself                                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface lvds_soft_deser_align_if;
  import lvds_pkg::*;

  logic                rx_in;
  logic                realign;
  logic [c_word_w-1:0] rx_data;
  logic                rx_valid;
  logic                rx_sync;
  logic                locked;
  logic                lock_lost;

  modport master (
    output rx_in, realign,
    input  rx_data, rx_valid, rx_sync, locked, lock_lost
  );

  modport slave (
    input  rx_in, realign,
    output rx_data, rx_valid, rx_sync, locked, lock_lost
  );

endinterface
`default_nettype wire

// File: rtl/lvds_soft_deser_align_bit_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lvds_bit_shift                                              |
// | Purpose    : Serial-in shift register (MSB first) and free-running 3-bit |
// |              bit counter with a synchronous clear used for alignment.    |
// | Ports      : clk, rst_n   - clock, async active-low reset                |
// |              rx_in        - serial bit sampled this edge                 |
// |              cnt_clr      - forces bit counter to 0 on the next edge     |
// |              word[7:0]    - {sr[6:0], rx_in}: word ending at this bit    |
// |              bit_cnt[2:0] - current bit counter value                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lvds_bit_shift
  import lvds_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                rx_in,
  input  wire logic                cnt_clr,
  output logic      [c_word_w-1:0] word,
  output logic      [2:0]          bit_cnt
);

  logic [c_word_w-1:0] sr_q, sr_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                w_sr_unused;

  always_comb begin
    sr_d      = {sr_q[c_word_w-2:0], rx_in};
    bit_cnt_d = cnt_clr ? 3'd0 : bit_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The word completed by the current bit is exactly the next shift value.
  assign word    = sr_d;
  assign bit_cnt = bit_cnt_q;

  // The oldest bit falls off the end once the next word is formed.
  assign w_sr_unused = sr_q[c_word_w-1];

endmodule
`default_nettype wire

// File: rtl/lvds_soft_deser_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lvds_soft_deser_align                                       |
// | Purpose    : Soft LVDS 8:1 receiver. Deserialises MSB first, hunts for   |
// |              SYNC_WORD at any bit offset, verifies LOCK_CNT aligned sync |
// |              words, then emits aligned words with a valid strobe.        |
// | Ports      : clk, rst_n   - bit clock, async active-low reset            |
// |              bus (slave)  - rx_in, realign in; rx_data, rx_valid,        |
// |                             rx_sync, locked, lock_lost out               |
// | Options    : LVDS_RX_RESYNC_EN - drop lock after FRAME_WORDS consecutive |
// |              non-sync words while LOCKED                                 |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lvds_soft_deser_align
  import lvds_pkg::*;
#(
  parameter logic [c_word_w-1:0] SYNC_WORD   = c_sync_word,
  parameter int unsigned         LOCK_CNT    = 4,
  parameter int unsigned         FRAME_WORDS = 64
) (
  input wire logic               clk,
  input wire logic               rst_n,
  lvds_soft_deser_align_if.slave bus
);

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);

  logic [c_word_w-1:0] w_word;
  logic [2:0]          w_bit_cnt;
  logic                w_boundary;
  logic                w_is_sync;
  logic                cnt_clr;

  lvds_state_e         state_q, state_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  logic [c_word_w-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_sync_q, rx_sync_d;
  logic                locked_q, locked_d;
  logic                lock_lost_q, lock_lost_d;

`ifdef LVDS_RX_RESYNC_EN
  localparam int unsigned c_wcnt_w = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  logic [c_wcnt_w-1:0] wcnt_q, wcnt_d;
`else
  logic [31:0]         w_frame_unused;
  assign w_frame_unused = FRAME_WORDS;
`endif

  lvds_bit_shift u_bit_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_in   (bus.rx_in),
    .cnt_clr (cnt_clr),
    .word    (w_word),
    .bit_cnt (w_bit_cnt)
  );

  assign w_boundary = (w_bit_cnt == 3'd7);
  assign w_is_sync  = (w_word == SYNC_WORD);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sync_d   = 1'b0;
    lock_lost_d = 1'b0;
    cnt_clr     = 1'b0;
`ifdef LVDS_RX_RESYNC_EN
    wcnt_d      = wcnt_q;
`endif

    // realign overrides everything, including a word completing this cycle.
    if (bus.realign) begin
      state_d     = HUNT;
      match_cnt_d = 4'd0;
      cnt_clr     = 1'b1;
      lock_lost_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        HUNT: begin
          // Bit-granular search: the boundary is wherever the sync word ends.
          if (w_is_sync) begin
            cnt_clr     = 1'b1;
            match_cnt_d = 4'd1;
            state_d     = (c_lock_cnt == 4'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (w_boundary) begin
            if (w_is_sync) begin
              match_cnt_d = match_cnt_q + 4'd1;
              if (match_cnt_d == c_lock_cnt) state_d = LOCKED;
            end else begin
              state_d     = HUNT;
              match_cnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            rx_data_d  = w_word;
            rx_valid_d = 1'b1;
            rx_sync_d  = w_is_sync;
`ifdef LVDS_RX_RESYNC_EN
            // The word that exhausts the frame budget is still delivered.
            if (w_is_sync) begin
              wcnt_d = '0;
            end else if (wcnt_q == c_wcnt_w'(FRAME_WORDS - 1)) begin
              wcnt_d      = '0;
              state_d     = HUNT;
              match_cnt_d = 4'd0;
              lock_lost_d = 1'b1;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_d     = HUNT;
          match_cnt_d = 4'd0;
        end
      endcase
    end

`ifdef LVDS_RX_RESYNC_EN
    // Each lock starts with a fresh frame budget.
    if (state_d != LOCKED) wcnt_d = '0;
`endif

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      match_cnt_q <= 4'd0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_sync_q   <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
`ifdef LVDS_RX_RESYNC_EN
      wcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sync_q   <= rx_sync_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
`ifdef LVDS_RX_RESYNC_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_sync   = rx_sync_q;
  assign bus.locked    = locked_q;
  assign bus.lock_lost = lock_lost_q;

endmodule
`default_nettype wire
